// File: rtl/wb_ram_arb2.sv
// Two-master Wishbone arbiter in front of a single RAM slave.
// Round-robin on ties, bus lock while the granted cycle stays up, ack timeout.
module wb_ram_arb2 #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                m_cyc_i,
    input  logic [1:0]                m_stb_i,
    input  logic [1:0]                m_we_i,
    input  logic [2*ADDR_WIDTH-1:0]   m_adr_i,
    input  logic [2*DATA_WIDTH-1:0]   m_dat_i,
    input  logic [2*SELECT_WIDTH-1:0] m_sel_i,
    output logic [2*DATA_WIDTH-1:0]   m_dat_o,
    output logic [1:0]                m_ack_o,
    output logic [1:0]                m_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDR_WIDTH-1:0]     s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_o,
    output logic [SELECT_WIDTH-1:0]   s_sel_o,
    input  logic [DATA_WIDTH-1:0]     s_dat_i,
    input  logic                      s_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } state_t;

    // A zero TIMEOUT still needs a legal one-bit counter.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit TMO_EN = (TIMEOUT > 0);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      err_q, err_d;

    logic                    g_cyc, g_stb, g_we;
    logic [ADDR_WIDTH-1:0]   g_adr;
    logic [DATA_WIDTH-1:0]   g_dat;
    logic [SELECT_WIDTH-1:0] g_sel;

    assign g_cyc = m_cyc_i[grant_q];
    assign g_stb = m_stb_i[grant_q];
    assign g_we  = m_we_i[grant_q];
    assign g_adr = grant_q ? m_adr_i[ADDR_WIDTH +: ADDR_WIDTH]
                           : m_adr_i[0 +: ADDR_WIDTH];
    assign g_dat = grant_q ? m_dat_i[DATA_WIDTH +: DATA_WIDTH]
                           : m_dat_i[0 +: DATA_WIDTH];
    assign g_sel = grant_q ? m_sel_i[SELECT_WIDTH +: SELECT_WIDTH]
                           : m_sel_i[0 +: SELECT_WIDTH];

    assign m_dat_o = {2{s_dat_i}};
    assign m_err_o = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = '0;
        err_d   = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        m_ack_o = '0;
        unique case (state_q)
            IDLE: begin
                if (m_cyc_i != 2'b00) begin
                    grant_d = (m_cyc_i == 2'b11) ? ~last_q : m_cyc_i[1];
                    last_d  = grant_d;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_cyc_o = g_cyc;
                s_stb_o = g_stb;
                s_we_o  = g_we;
                s_adr_o = g_adr;
                s_dat_o = g_dat;
                s_sel_o = g_sel;
                m_ack_o[grant_q] = s_ack_i;
                if (g_stb && !s_ack_i && cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (g_stb && !s_ack_i) begin
                    cnt_d = cnt_q;
                end
                // A late ack always beats the timeout in the same cycle.
                if (TMO_EN && g_stb && !s_ack_i && cnt_q == CLAST) begin
                    err_d[grant_q] = 1'b1;
                    state_d = ABORT;
                end else if (!g_cyc) begin
                    state_d = IDLE;
                end
            end
            ABORT: begin
                if (!g_cyc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_ram_arb2.sv
// Scoreboard bench for wb_ram_arb2 with a short ack timeout.
// Slave responses are scripted; every ack/err the DUT emits is matched in order.
module tb_wb_ram_arb2;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_cyc_i, m_stb_i, m_we_i;
    logic [63:0] m_adr_i, m_dat_i;
    logic [7:0]  m_sel_i;
    logic [63:0] m_dat_o;
    logic [1:0]  m_ack_o, m_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    wb_ram_arb2 #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m_cyc_i(m_cyc_i),
        .m_stb_i(m_stb_i),
        .m_we_i(m_we_i),
        .m_adr_i(m_adr_i),
        .m_dat_i(m_dat_i),
        .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o),
        .m_ack_o(m_ack_o),
        .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o),
        .s_stb_o(s_stb_o),
        .s_we_o(s_we_o),
        .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int k, input logic c, input logic s,
                       input logic w, input logic [31:0] a,
                       input logic [31:0] d);
        m_cyc_i[k] = c;
        m_stb_i[k] = s;
        m_we_i[k]  = w;
        m_adr_i[k*32 +: 32] = a;
        m_dat_i[k*32 +: 32] = d;
        m_sel_i[k*4 +: 4]   = 4'hF;
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] e,
                        input logic [31:0] d);
        exp_t x;
        x.ack = a;
        x.err = e;
        x.dat = d;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst && (m_ack_o != 2'b00 || m_err_o != 2'b00)) begin
            if (sb.size() == 0) begin
                chk("unexp_resp", {60'd0, m_ack_o, m_err_o}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack", {62'd0, m_ack_o}, {62'd0, e.ack});
                chk("err", {62'd0, m_err_o}, {62'd0, e.err});
                if (e.ack != 2'b00) chk("rdat", m_dat_o, {2{e.dat}});
            end
        end
    end

    initial begin
        rst = 1'b1;
        m_cyc_i = '0; m_stb_i = '0; m_we_i = '0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
        s_dat_i = '0; s_ack_i = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_cyc", {63'd0, s_cyc_o}, 64'd0);
        chk("rst_stb", {63'd0, s_stb_o}, 64'd0);
        chk("rst_ack", {62'd0, m_ack_o}, 64'd0);
        chk("rst_err", {62'd0, m_err_o}, 64'd0);
        cyc();
        rst = 1'b0;

        // single master read
        drv(0, 1, 1, 0, 32'h10, 0);
        @(negedge clk);
        chk("t1_idle", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        @(negedge clk);
        chk("t1_cyc", {63'd0, s_cyc_o}, 64'd1);
        chk("t1_adr", {32'd0, s_adr_o}, 64'h10);
        chk("t1_we", {63'd0, s_we_o}, 64'd0);
        cyc();
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEADBEEF;
        push(2'b01, 2'b00, 32'hDEADBEEF);
        cyc();
        s_ack_i = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_rel", {63'd0, s_cyc_o}, 64'd0);
        cyc();

        // reset in the middle of a write
        drv(1, 1, 1, 1, 32'h44, 32'h55);
        cyc();
        @(negedge clk);
        chk("t6_busy", {63'd0, s_cyc_o}, 64'd1);
        chk("t6_we", {63'd0, s_we_o}, 64'd1);
        cyc();
        #2;
        rst = 1'b1;
        s_ack_i = 1'b1;
        #1;
        chk("t6_cyc", {63'd0, s_cyc_o}, 64'd0);
        chk("t6_stb", {63'd0, s_stb_o}, 64'd0);
        chk("t6_ack", {62'd0, m_ack_o}, 64'd0);
        chk("t6_err", {62'd0, m_err_o}, 64'd0);
        s_ack_i = 1'b0;
        drv(0, 1, 1, 0, 32'h100, 32'hA);
        drv(1, 1, 1, 0, 32'h200, 32'hB);
        cyc();
        cyc();
        rst = 1'b0;

        // contention: tie after reset goes to m0, then alternate
        @(negedge clk);
        chk("t2_idle", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        @(negedge clk);
        chk("t2_g0", {32'd0, s_adr_o}, 64'h100);
        cyc();
        s_ack_i = 1'b1;
        s_dat_i = 32'h1111;
        push(2'b01, 2'b00, 32'h1111);
        cyc();
        s_ack_i = 1'b0;
        drv(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t2_rel", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        @(negedge clk);
        chk("t2_gap", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        @(negedge clk);
        chk("t2_g1", {32'd0, s_adr_o}, 64'h200);
        cyc();
        s_ack_i = 1'b1;
        s_dat_i = 32'h2222;
        push(2'b10, 2'b00, 32'h2222);
        cyc();
        s_ack_i = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        cyc();
        drv(0, 1, 1, 0, 32'h100, 0);
        drv(1, 1, 1, 0, 32'h200, 0);
        cyc();
        @(negedge clk);
        chk("t2_alt", {32'd0, s_adr_o}, 64'h100);
        cyc();
        drv(0, 0, 0, 0, 0, 0);
        cyc();
        cyc();

        // bus lock: m1 keeps cyc over four writes while m0 waits
        drv(0, 1, 1, 0, 32'h180, 0);
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 1, 1, 32'h300 + 32'(4 * i), 32'(i));
            s_ack_i = 1'b1;
            s_dat_i = 32'h0;
            push(2'b10, 2'b00, 32'h0);
            @(negedge clk);
            chk("t3_adr", {32'd0, s_adr_o}, 64'h300 + 64'(4 * i));
            cyc();
        end
        s_ack_i = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t3_drop", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        cyc();
        @(negedge clk);
        chk("t3_m0", {32'd0, s_adr_o}, 64'h180);

        // timeout: m0 strobe never acked
        s_dat_i = 32'h77;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                cyc();
                @(negedge clk);
            end
            chk("t4_noerr", {62'd0, m_err_o}, 64'd0);
        end
        push(2'b00, 2'b01, 32'h77);
        cyc();
        @(negedge clk);
        chk("t4_abort", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        @(negedge clk);
        chk("t4_hold", {63'd0, s_cyc_o}, 64'd0);
        chk("t4_pulse", {62'd0, m_err_o}, 64'd0);
        drv(0, 0, 0, 0, 0, 0);
        cyc();

        // ack on the last wait cycle wins over the timeout
        drv(1, 1, 1, 0, 32'h400, 0);
        cyc();
        cyc();
        cyc();
        cyc();
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE0001;
        push(2'b10, 2'b00, 32'hCAFE0001);
        cyc();
        s_ack_i = 1'b0;
        @(negedge clk);
        chk("t5_noerr", {62'd0, m_err_o}, 64'd0);
        chk("t5_busy", {63'd0, s_cyc_o}, 64'd1);
        cyc();
        // cyc dropped together with ack: ack still forwarded
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE0002;
        drv(1, 0, 0, 0, 32'h400, 0);
        push(2'b10, 2'b00, 32'hCAFE0002);
        @(negedge clk);
        chk("t5_dropcyc", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        s_ack_i = 1'b0;
        @(negedge clk);
        chk("t5_idle", {63'd0, s_cyc_o}, 64'd0);
        cyc();
        cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_ram_arb2.md
WB_RAM_ARB2 -- requirements
Module: wb_ram_arb2

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits (8, 16, 32 or 64).
REQ-002 Parameter ADDR_WIDTH, default 32, address bus width in bits.
REQ-003 Parameter SELECT_WIDTH, default DATA_WIDTH/8, byte-select width.
REQ-004 Parameter TIMEOUT, default 255, maximum cycles to wait for slave ack; 0 disables the timeout.
REQ-005 The block SHALL use one clock, clk, and an asynchronous, active-high reset, rst.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 m_cyc_i  input  2  per-master cycle request; bit k is master k.
REQ-009 m_stb_i  input  2  per-master strobe.
REQ-010 m_we_i  input  2  per-master write enable.
REQ-011 m_adr_i  input  2*ADDR_WIDTH  master k address in slice [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-012 m_dat_i  input  2*DATA_WIDTH  master k write data, same slicing.
REQ-013 m_sel_i  input  2*SELECT_WIDTH  master k byte selects, same slicing.
REQ-014 m_dat_o  output  2*DATA_WIDTH  read data; both slices equal s_dat_i.
REQ-015 m_ack_o  output  2  per-master acknowledge.
REQ-016 m_err_o  output  2  per-master timeout error pulse.
REQ-017 s_cyc_o, s_stb_o, s_we_o  output  1 each  slave cycle, strobe, write enable.
REQ-018 s_adr_o  output  ADDR_WIDTH  slave address.
REQ-019 s_dat_o  output  DATA_WIDTH  slave write data.
REQ-020 s_sel_o  output  SELECT_WIDTH  slave byte selects.
REQ-021 s_dat_i  input  DATA_WIDTH  slave read data.
REQ-022 s_ack_i  input  1  slave acknowledge.

Function
REQ-023 Registered state machine, states IDLE, BUSY, ABORT; registered grant (1 bit) and last_grant (1 bit).
REQ-024 IDLE: s_cyc_o, s_stb_o, s_we_o low; s_adr_o, s_dat_o, s_sel_o zero; m_ack_o, m_err_o zero.
REQ-025 IDLE, exactly one m_cyc_i bit high: next edge grant=that master, state BUSY.
REQ-026 IDLE, both m_cyc_i high: round-robin, grant = ~last_grant; next edge state BUSY.
REQ-027 Entering BUSY: last_grant <= grant value being loaded.
REQ-028 BUSY: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o combinationally equal granted master's inputs; non-granted master sees no ack/err.
REQ-029 BUSY: m_ack_o[grant] = s_ack_i combinationally; other bit 0.
REQ-030 BUSY persists while m_cyc_i[grant] high (bus lock over multiple transfers); m_cyc_i[grant] low -> next edge IDLE; minimum one IDLE cycle between grants.
REQ-031 Wait counter, width $clog2(TIMEOUT+1): cleared when not BUSY, s_stb_o low or s_ack_i high; else increments, saturating.
REQ-032 TIMEOUT>0, BUSY, counter==TIMEOUT-1, s_stb_o high, s_ack_i low: next edge m_err_o[grant]=1 for exactly one cycle, state ABORT.
REQ-033 s_ack_i high in the cycle the timeout would fire: ack wins, no error, counter cleared.
REQ-034 ABORT: slave outputs as IDLE; m_ack_o zero; stays until m_cyc_i[grant] low, then next edge IDLE.
REQ-035 m_cyc_i[grant] dropped in the same cycle as s_ack_i: ack still forwarded that cycle; next edge IDLE.
REQ-036 m_dat_o both slices = s_dat_i at all times (masters qualify with ack).

Reset
REQ-037 rst high: state IDLE, grant 0, last_grant 1, counter 0, m_err_o 0, immediately and asynchronously; slave outputs drop in the same cycle.
REQ-038 Reset mid-transfer: in-flight access abandoned, no ack/err delivered; after rst release both masters re-arbitrate from IDLE with master 0 winning a tie.

Verification
REQ-039 Single master: m0 reads adr 0x10, slave acks 1 cycle after stb with 0xDEADBEEF -> s_cyc_o rises cycle after m_cyc_i[0], m_ack_o=2'b01 one cycle, m_dat_o[31:0]=0xDEADBEEF.
REQ-040 Contention: both cyc rise together after reset -> m0 granted first; m0 releases -> one IDLE cycle -> m1 granted; both again -> m0 (alternation).
REQ-041 Bus lock: m1 holds cyc across 4 writes, m0 requesting -> s_adr_o tracks only m1 for all 4; m0 granted only after m1 drops cyc.
REQ-042 Timeout: TIMEOUT=4, slave never acks -> m_err_o[grant] pulses 1 cycle, 4 cycles after stb, s_cyc_o low in ABORT until master drops cyc.
REQ-043 Ack at boundary: TIMEOUT=4, ack in 4th wait cycle -> m_ack_o pulse, no m_err_o.
REQ-044 Reset mid-write: rst asserted while BUSY with stb high -> s_cyc_o/s_stb_o low same cycle, no ack/err, last_grant=1.
